// File: rtl/pio_rr_arbiter.sv
// Round-robin arbiter letting two Avalon-MM masters share one PIO slave, one transaction in flight.
// Command issues the cycle after the grant decision; losers stall on waitrequest until their own issue cycle.
module pio_rr_arbiter #(
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic [ADDR_W-1:0] s_address,
    output logic              s_chipselect,
    output logic              s_write_n,
    output logic [DATA_W-1:0] s_writedata,
    input  logic [DATA_W-1:0] s_readdata,
    output logic [1:0]        grant
);
    localparam int              CNT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_RDWAIT = 2'd2,
        S_RDCAP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [1:0]         r_grant;
    logic               r_last;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic               r_op_wr;
    logic [CNT_W-1:0]   r_cnt;
    logic [DATA_W-1:0]  r_rdata0;
    logic [DATA_W-1:0]  r_rdata1;
    logic [1:0]         r_rdv;

    logic w_req0;
    logic w_req1;
    logic w_pick1;
    logic w_issue;
    logic w_rdwait;

    assign w_req0   = m0_read | m0_write;
    assign w_req1   = m1_read | m1_write;
    // On a tie the port that did not win last time takes the grant.
    assign w_pick1  = w_req1 & (~w_req0 | ~r_last);
    assign w_issue  = (r_state == S_ISSUE);
    assign w_rdwait = (r_state == S_RDWAIT);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (w_req0 | w_req1) w_next_state = S_ISSUE;
            S_ISSUE:  w_next_state = r_op_wr ? S_IDLE : S_RDWAIT;
            S_RDWAIT: if (r_cnt == '0) w_next_state = S_RDCAP;
            S_RDCAP:  w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_grant  <= 2'b00;
            r_last   <= 1'b1;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_op_wr  <= 1'b0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_rdv    <= 2'b00;
        end else begin
            r_rdv <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_req0 | w_req1) begin
                        r_grant <= w_pick1 ? 2'b10 : 2'b01;
                        r_last  <= w_pick1;
                        r_addr  <= w_pick1 ? m1_address   : m0_address;
                        r_wdata <= w_pick1 ? m1_writedata : m0_writedata;
                        r_op_wr <= w_pick1 ? m1_write     : m0_write;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= CNT_LOAD;
                    if (r_op_wr) r_grant <= 2'b00;
                end
                S_RDWAIT: begin
                    if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                end
                S_RDCAP: begin
                    if (r_grant[0]) r_rdata0 <= s_readdata;
                    if (r_grant[1]) r_rdata1 <= s_readdata;
                    r_rdv   <= r_grant;
                    r_grant <= 2'b00;
                end
                default: r_grant <= 2'b00;
            endcase
        end
    end

    // Slave bus is forced quiet outside the issue/read-wait window.
    assign s_chipselect     = w_issue;
    assign s_write_n        = ~(w_issue & r_op_wr);
    assign s_address        = (w_issue | w_rdwait) ? r_addr : '0;
    assign s_writedata      = w_issue ? r_wdata : '0;
    assign m0_waitrequest   = ~(w_issue & r_grant[0]);
    assign m1_waitrequest   = ~(w_issue & r_grant[1]);
    assign m0_readdata      = r_rdata0;
    assign m1_readdata      = r_rdata1;
    assign m0_readdatavalid = r_rdv[0];
    assign m1_readdatavalid = r_rdv[1];
    assign grant            = r_grant;
endmodule

// File: tb/tb_pio_rr_arbiter.sv
// Directed scoreboard bench: instance 0 uses READ_LATENCY=1, instance 1 uses READ_LATENCY=3.
module tb_pio_rr_arbiter;
    typedef struct packed {
        logic [1:0]  grant;
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] data;
    } bus_t;
    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic [7:0]  lat;
    } rd_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  ma    [2][2];
    logic        mr    [2][2];
    logic        mw    [2][2];
    logic [31:0] mwd   [2][2];
    logic        mwait [2][2];
    logic [31:0] mrd   [2][2];
    logic        mrdv  [2][2];
    logic [2:0]  sa    [2];
    logic        scs   [2];
    logic        swn   [2];
    logic [31:0] swd   [2];
    logic [31:0] srd   [2];
    logic [1:0]  gnt   [2];
    logic [31:0] inp   [2];

    bus_t exp_bus [2][$];
    rd_t  exp_rd  [2][$];
    int   n_pass = 0;
    int   n_total = 0;
    int   cyc = 0;
    int   issue_cyc [2];
    int   wlow [2][2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pio_rr_arbiter #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n),
        .m0_address(ma[0][0]), .m0_read(mr[0][0]), .m0_write(mw[0][0]), .m0_writedata(mwd[0][0]),
        .m0_waitrequest(mwait[0][0]), .m0_readdata(mrd[0][0]), .m0_readdatavalid(mrdv[0][0]),
        .m1_address(ma[0][1]), .m1_read(mr[0][1]), .m1_write(mw[0][1]), .m1_writedata(mwd[0][1]),
        .m1_waitrequest(mwait[0][1]), .m1_readdata(mrd[0][1]), .m1_readdatavalid(mrdv[0][1]),
        .s_address(sa[0]), .s_chipselect(scs[0]), .s_write_n(swn[0]), .s_writedata(swd[0]),
        .s_readdata(srd[0]), .grant(gnt[0])
    );

    pio_rr_arbiter #(.ADDR_W(3), .DATA_W(32), .READ_LATENCY(3)) u_dut1 (
        .clk(clk), .reset_n(reset_n),
        .m0_address(ma[1][0]), .m0_read(mr[1][0]), .m0_write(mw[1][0]), .m0_writedata(mwd[1][0]),
        .m0_waitrequest(mwait[1][0]), .m0_readdata(mrd[1][0]), .m0_readdatavalid(mrdv[1][0]),
        .m1_address(ma[1][1]), .m1_read(mr[1][1]), .m1_write(mw[1][1]), .m1_writedata(mwd[1][1]),
        .m1_waitrequest(mwait[1][1]), .m1_readdata(mrd[1][1]), .m1_readdatavalid(mrdv[1][1]),
        .s_address(sa[1]), .s_chipselect(scs[1]), .s_write_n(swn[1]), .s_writedata(swd[1]),
        .s_readdata(srd[1]), .grant(gnt[1])
    );

    // PIO slave model: registered readdata, address 0 returns the input port.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            srd[d] <= (sa[d] == 3'd0) ? inp[d] : (32'hD00D_0000 | {29'd0, sa[d]});
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic mon(input int d);
        bus_t e;
        rd_t  r;
        if (scs[d]) begin
            if (exp_bus[d].size() == 0) check("bus_unexpected", {63'd0, scs[d]}, 64'd0);
            else begin
                e = exp_bus[d].pop_front();
                check("bus_op", {26'd0, gnt[d], swn[d], sa[d], swd[d]},
                      {26'd0, e.grant, ~e.wr, e.addr, e.data});
                if (!e.wr) issue_cyc[d] = cyc;
            end
        end
        for (int p = 0; p < 2; p++) if (mwait[d][p] === 1'b0) wlow[d][p]++;
        if (mrdv[d][0] !== 1'b0 || mrdv[d][1] !== 1'b0) begin
            if (exp_rd[d].size() == 0)
                check("rdv_unexpected", {62'd0, mrdv[d][1], mrdv[d][0]}, 64'd0);
            else begin
                r = exp_rd[d].pop_front();
                check("rd_data", {30'd0, mrdv[d][1], mrdv[d][0], mrd[d][r.port]},
                      {30'd0, r.port, ~r.port, r.data});
                check("rd_latency", 64'(cyc - issue_cyc[d]), {56'd0, r.lat});
            end
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) mon(d);
    end

    task automatic drive(input int d, input int p, input logic rd, input logic wr,
                         input logic [2:0] a, input logic [31:0] dat);
        ma[d][p] = a; mr[d][p] = rd; mw[d][p] = wr; mwd[d][p] = dat;
    endtask

    task automatic wait_accept(input int d, input int p);
        bit done = 0;
        for (int i = 0; i < 30 && !done; i++) begin
            @(negedge clk);
            if (mwait[d][p] === 1'b0) done = 1;
        end
        if (!done) check("accept_timeout", {63'd0, mwait[d][p]}, 64'd0);
        @(posedge clk); #1;
        drive(d, p, 1'b0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic rst_check(input int d);
        check("rst_ctrl", {58'd0, mwait[d][1], mwait[d][0], swn[d], scs[d], gnt[d]}, 64'b111000);
        check("rst_bus", {29'd0, sa[d], swd[d]}, 64'd0);
        check("rst_rd", {62'd0, mrdv[d][1], mrdv[d][0]} | {32'd0, mrd[d][0] | mrd[d][1]}, 64'd0);
    endtask

    task automatic clear_wlow();
        for (int d = 0; d < 2; d++) for (int p = 0; p < 2; p++) wlow[d][p] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            issue_cyc[d] = 0;
            for (int p = 0; p < 2; p++) drive(d, p, 1'b0, 1'b0, 3'd0, 32'd0);
        end
        inp[0] = 32'h3C;
        inp[1] = 32'hC3;
        clear_wlow();
        repeat (2) @(negedge clk);
        rst_check(0);
        rst_check(1);
        @(posedge clk); #1 reset_n = 1'b1;

        // m0 write alone
        clear_wlow();
        exp_bus[0].push_back('{2'b01, 1'b1, 3'd0, 32'hA5});
        drive(0, 0, 1'b0, 1'b1, 3'd0, 32'hA5);
        wait_accept(0, 0);
        repeat (4) @(negedge clk);
        check("t1_wlow_m0", 64'(wlow[0][0]), 64'd1);
        check("t1_wlow_m1", 64'(wlow[0][1]), 64'd0);
        check("t1_drain", 64'(exp_bus[0].size()), 64'd0);

        // m1 read of input port
        clear_wlow();
        exp_bus[0].push_back('{2'b10, 1'b0, 3'd0, 32'd0});
        exp_rd[0].push_back('{1'b1, 32'h3C, 8'd3});
        drive(0, 1, 1'b1, 1'b0, 3'd0, 32'd0);
        wait_accept(0, 1);
        repeat (6) @(negedge clk);
        check("t2_bus_drain", 64'(exp_bus[0].size()), 64'd0);
        check("t2_rd_drain", 64'(exp_rd[0].size()), 64'd0);
        check("t2_wlow", {32'(wlow[0][0]), 32'(wlow[0][1])}, {32'd0, 32'd1});

        // both masters writing continuously after a fresh reset
        @(posedge clk); #1 reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_bus[0].push_back('{2'b01, 1'b1, 3'd1, 32'h11});
            exp_bus[0].push_back('{2'b10, 1'b1, 3'd2, 32'h22});
        end
        drive(0, 0, 1'b0, 1'b1, 3'd1, 32'h11);
        drive(0, 1, 1'b0, 1'b1, 3'd2, 32'h22);
        n = 0;
        for (int i = 0; i < 40 && n < 6; i++) begin
            @(negedge clk);
            if (scs[0] === 1'b1) n++;
        end
        drive(0, 0, 1'b0, 1'b0, 3'd0, 32'd0);
        drive(0, 1, 1'b0, 1'b0, 3'd0, 32'd0);
        repeat (4) @(negedge clk);
        check("t3_issues", 64'(n), 64'd6);
        check("t3_drain", 64'(exp_bus[0].size()), 64'd0);

        // reset asserted while the read is waiting on the slave
        exp_bus[0].push_back('{2'b01, 1'b0, 3'd0, 32'd0});
        drive(0, 0, 1'b1, 1'b0, 3'd0, 32'd0);
        wait_accept(0, 0);
        reset_n = 1'b0;
        @(negedge clk);
        rst_check(0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t4_bus_drain", 64'(exp_bus[0].size()), 64'd0);
        exp_bus[0].push_back('{2'b10, 1'b1, 3'd3, 32'h77});
        drive(0, 1, 1'b0, 1'b1, 3'd3, 32'h77);
        wait_accept(0, 1);
        repeat (3) @(negedge clk);
        check("t4_next_served", 64'(exp_bus[0].size()), 64'd0);

        // read and write together on one port is a write
        exp_bus[0].push_back('{2'b01, 1'b1, 3'd4, 32'h0F});
        drive(0, 0, 1'b1, 1'b1, 3'd4, 32'h0F);
        wait_accept(0, 0);
        repeat (5) @(negedge clk);
        check("t5_drain", 64'(exp_bus[0].size()), 64'd0);
        check("t5_no_read", 64'(exp_rd[0].size()), 64'd0);

        // longer slave read latency
        exp_bus[1].push_back('{2'b01, 1'b0, 3'd5, 32'd0});
        exp_rd[1].push_back('{1'b0, 32'hD00D_0005, 8'd5});
        drive(1, 0, 1'b1, 1'b0, 3'd5, 32'd0);
        wait_accept(1, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t6_rdwait", {59'd0, scs[1], swn[1], sa[1]}, {59'd0, 1'b0, 1'b1, 3'd5});
        end
        @(negedge clk);
        check("t6_rdcap_addr", {61'd0, sa[1]}, 64'd0);
        repeat (4) @(negedge clk);
        check("t6_bus_drain", 64'(exp_bus[1].size()), 64'd0);
        check("t6_rd_drain", 64'(exp_rd[1].size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
